// File: rtl/timer_unit.sv
// timer_unit: second-based countdown / count-up timer with pause, abort,
// warning threshold, stretched done pulse and BCD display output.
module timer_unit #(
    parameter int CLK_FREQ         = 100000000,
    parameter int CNT_W            = 8,
    parameter int DONE_HOLD_CYCLES = 5,
    parameter int BCD_DIGITS       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    abort,
    input  logic                    mode,
    input  logic [CNT_W-1:0]        load_value,
    input  logic [CNT_W-1:0]        warn_level,
    output logic [CNT_W-1:0]        current_value,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    busy,
    output logic                    paused,
    output logic                    tick,
    output logic                    warn,
    output logic                    done
);

    localparam int DIV_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int HOLD_W = $clog2(DONE_HOLD_CYCLES + 1);
    localparam int FULL_D = CNT_W / 3 + 1;
    localparam int TOT_D  = (FULL_D > BCD_DIGITS) ? FULL_D : BCD_DIGITS;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_FREQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE_HOLD
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               mode_r;
    logic [CNT_W-1:0]   target_r;
    logic [CNT_W:0]     up_next;
    logic [CNT_W-1:0]   remaining;
    logic [4*TOT_D-1:0] dd;

    // Widened so that the up-count compare cannot wrap at the top of range.
    assign up_next = {1'b0, current_value} + {{CNT_W{1'b0}}, 1'b1};

    // Main controller: command priority abort > start > pause > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            div_cnt       <= '0;
            hold_cnt      <= '0;
            mode_r        <= 1'b0;
            target_r      <= '0;
            current_value <= '0;
            busy          <= 1'b0;
            paused        <= 1'b0;
            tick          <= 1'b0;
            done          <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (abort) begin
                if (state != IDLE) begin
                    state         <= IDLE;
                    current_value <= '0;
                    div_cnt       <= '0;
                    hold_cnt      <= '0;
                    busy          <= 1'b0;
                    paused        <= 1'b0;
                    done          <= 1'b0;
                end
            end else if (start) begin
                state    <= RUN;
                mode_r   <= mode;
                div_cnt  <= '0;
                hold_cnt <= '0;
                busy     <= 1'b1;
                paused   <= 1'b0;
                done     <= 1'b0;
                if (mode) begin
                    current_value <= '0;
                    target_r      <= load_value;
                end else begin
                    current_value <= load_value;
                end
            end else begin
                unique case (state)
                    RUN: begin
                        if (pause) begin
                            state  <= PAUSE;
                            paused <= 1'b1;
                        end else if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            tick    <= 1'b1;
                            if (!mode_r) begin
                                if (current_value <= CNT_W'(1)) begin
                                    current_value <= '0;
                                    state         <= DONE_HOLD;
                                    busy          <= 1'b0;
                                    done          <= 1'b1;
                                    hold_cnt      <= '0;
                                end else begin
                                    current_value <= current_value - CNT_W'(1);
                                end
                            end else begin
                                if (up_next >= {1'b0, target_r}) begin
                                    current_value <= target_r;
                                    state         <= DONE_HOLD;
                                    busy          <= 1'b0;
                                    done          <= 1'b1;
                                    hold_cnt      <= '0;
                                end else begin
                                    current_value <= up_next[CNT_W-1:0];
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (pause) begin
                            state  <= RUN;
                            paused <= 1'b0;
                        end
                    end
                    DONE_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= IDLE;
                            done  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Remaining count toward completion, compared live against the threshold.
    always_comb begin
        remaining = mode_r ? (target_r - current_value) : current_value;
        warn      = busy && (remaining <= warn_level);
    end

    // Double-dabble conversion; the low digits give the value modulo 10^digits.
    always_comb begin
        dd = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            for (int d = 0; d < TOT_D; d++) begin
                if (dd[4*d +: 4] >= 4'd5) begin
                    dd[4*d +: 4] = dd[4*d +: 4] + 4'd3;
                end
            end
            dd = {dd[4*TOT_D-2:0], current_value[i]};
        end
        bcd_out = dd[4*BCD_DIGITS-1:0];
    end

endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed and randomized checks of timer_unit against a
// tick-counting behavioural model.
module tb_timer_unit;

    localparam int CF = 4;
    localparam int W  = 8;
    localparam int H  = 3;
    localparam int D  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] warn_level = '0;
    logic [W-1:0] current_value;
    logic [11:0]  bcd_out;
    logic         busy, paused, tick, warn, done;

    int checks = 0;
    int errors = 0;

    // Model: a run is described by elapsed running cycles and ticks taken.
    bit m_busy, m_paused, m_up, m_tick;
    int m_val, m_tgt, m_lim, m_elapsed, m_ticks, m_hold;

    timer_unit #(
        .CLK_FREQ(CF), .CNT_W(W), .DONE_HOLD_CYCLES(H), .BCD_DIGITS(D)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .abort(abort), .mode(mode), .load_value(load_value),
        .warn_level(warn_level), .current_value(current_value),
        .bcd_out(bcd_out), .busy(busy), .paused(paused), .tick(tick),
        .warn(warn), .done(done)
    );

    always #5 clk = ~clk;

    wire [24:0] dut_vec = {current_value, bcd_out, busy, paused, tick, warn, done};

    function automatic void model_step(bit r, bit s, bit p, bit a, bit m, int lv);
        m_tick = 0;
        if (r) begin
            m_busy = 0; m_paused = 0; m_up = 0; m_val = 0; m_tgt = 0;
            m_lim = 0; m_elapsed = 0; m_ticks = 0; m_hold = 0;
        end else if (a) begin
            if (m_busy || m_hold > 0) begin
                m_busy = 0; m_paused = 0; m_hold = 0; m_val = 0;
            end
        end else if (s) begin
            m_busy = 1; m_paused = 0; m_hold = 0; m_up = m;
            m_lim = lv; m_elapsed = 0; m_ticks = 0;
            if (m) begin m_val = 0; m_tgt = lv; end
            else m_val = lv;
        end else if (m_busy && p) begin
            m_paused = !m_paused;
        end else if (m_busy && !m_paused) begin
            m_elapsed++;
            if (m_elapsed % CF == 0) begin
                m_tick = 1;
                m_ticks++;
                if (m_up) m_val = (m_ticks < m_tgt) ? m_ticks : m_tgt;
                else m_val = (m_lim > m_ticks) ? m_lim - m_ticks : 0;
                if (m_ticks >= ((m_lim > 1) ? m_lim : 1)) begin
                    m_busy = 0;
                    m_hold = H;
                end
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end
    endfunction

    function automatic logic [24:0] exp_vec();
        int rem;
        bit w;
        logic [11:0] b;
        rem = m_up ? m_tgt - m_val : m_val;
        w = m_busy && (rem <= int'(warn_level));
        b = {4'(m_val / 100 % 10), 4'(m_val / 10 % 10), 4'(m_val % 10)};
        return {8'(m_val), b, m_busy, m_paused, m_tick, w, (m_hold > 0)};
    endfunction

    task automatic cyc(input bit r, input bit s, input bit p, input bit a,
                       input bit m, input int lv);
        reset = r; start = s; pause = p; abort = a; mode = m;
        load_value = W'(lv);
        @(posedge clk);
        model_step(r, s, p, a, m, lv);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== 25'd0) begin
                errors++;
                $display("FAIL reset: got %h want 0", dut_vec);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_down();
        warn_level = 8'd0;
        cyc(0, 1, 0, 0, 0, 3);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, 0, 0, 0, 3);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL down k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
            checks++;
            if (tick !== (k == 4 || k == 8 || k == 12)) begin
                errors++;
                $display("FAIL down_tick k=%0d: got %b", k, tick);
            end
            checks++;
            if (done !== (k >= 12 && k <= 14) || busy !== (k < 12)) begin
                errors++;
                $display("FAIL down_done k=%0d: done %b busy %b", k, done, busy);
            end
        end
    endtask

    task automatic test_up();
        warn_level = 8'd1;
        cyc(0, 1, 0, 0, 1, 2);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL up k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
            checks++;
            if (warn !== (k >= 4 && k < 8)) begin
                errors++;
                $display("FAIL up_warn k=%0d: got %b", k, warn);
            end
            if (k == 8) begin
                checks++;
                if (done !== 1'b1 || bcd_out !== 12'h002) begin
                    errors++;
                    $display("FAIL up_done: done %b bcd %h want 1 002", done, bcd_out);
                end
            end
        end
    endtask

    task automatic test_pause();
        warn_level = 8'd0;
        cyc(0, 1, 0, 0, 0, 5);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, (k == 7 || k == 17), 0, 0, 5);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL pause k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
            checks++;
            if (paused !== (k >= 7 && k <= 16) || tick !== (k == 4 || k == 19)) begin
                errors++;
                $display("FAIL pause_seq k=%0d: paused %b tick %b", k, paused, tick);
            end
            if (k == 19) begin
                checks++;
                if (current_value !== 8'd3) begin
                    errors++;
                    $display("FAIL pause_val: got %0d want 3", current_value);
                end
            end
        end
    endtask

    task automatic test_bcd();
        cyc(0, 1, 0, 0, 0, 200);
        checks++;
        if (bcd_out !== 12'h200) begin
            errors++;
            $display("FAIL bcd_200: got %h want 200", bcd_out);
        end
        for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 0, 0, 200);
        checks++;
        if (bcd_out !== 12'h199 || tick !== 1'b1) begin
            errors++;
            $display("FAIL bcd_199: got %h tick %b want 199 1", bcd_out, tick);
        end
        cyc(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_abort();
        cyc(0, 1, 0, 0, 0, 9);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 0, 0, (k == 5), 0, 9);
            if (k == 5) begin
                checks++;
                if (busy !== 1'b0 || current_value !== 8'd0) begin
                    errors++;
                    $display("FAIL abort: busy %b val %0d want 0 0", busy, current_value);
                end
            end
            checks++;
            if (done !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL abort_seq k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        cyc(0, 1, 0, 1, 0, 9);
        cyc(0, 0, 0, 0, 0, 9);
        checks++;
        if (busy !== 1'b0 || current_value !== 8'd0) begin
            errors++;
            $display("FAIL start_abort: busy %b val %0d want 0 0", busy, current_value);
        end
    endtask

    task automatic test_back_to_back();
        cyc(0, 1, 0, 0, 0, 3);
        for (int k = 1; k <= 6; k++) cyc(0, 0, 0, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec !== 25'd0) begin
            errors++;
            $display("FAIL reset_run: got %h want 0", dut_vec);
        end
        cyc(0, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 0, 0, 1);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL hold_enter: done %b want 1", done);
        end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec !== 25'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h want 0", dut_vec);
        end
        cyc(0, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 7);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || current_value !== 8'd7) begin
            errors++;
            $display("FAIL restart_hold: done %b busy %b val %0d want 0 1 7",
                     done, busy, current_value);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 49) == 0) warn_level = W'($urandom_range(0, 12));
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 14) == 0),
                ($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 12)));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_step(1, 0, 0, 0, 0, 0);
        test_reset();
        test_down();
        test_up();
        test_pause();
        test_bcd();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
